spi_slave_port: RTL
===================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 Parameter FRAME_BITS, default 16: bits per frame, counted on sclk rising edges.
REQ-002 Parameter RESP_BITS, default 8: response bits, driven during the last RESP_BITS bit-times of the frame.
REQ-003 clk  input  1  system clock, 100 MHz; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; rst=0 forces the reset state immediately.
REQ-005 ss_n  input  1  slave select from the master, active-low, asynchronous to clk.
REQ-006 sclk  input  1  serial clock from the master, idles high, asynchronous to clk.
REQ-007 sdi  input  1  serial data from the master, MSB first, asynchronous to clk.
REQ-008 sdo  output  1  serial data to the master, MSB first; high when not driving response bits.
REQ-009 txdata  input  RESP_BITS  response word, sampled once per frame at frame start.
REQ-010 rxdata  output  FRAME_BITS  last complete received frame; holds its value until the next complete frame.
REQ-011 rx_valid  output  1  one-clk pulse when rxdata is updated.
REQ-012 busy  output  1  high from detected frame start until return to IDLE.
REQ-013 frame_err  output  1  one-clk pulse when ss_n deasserts before FRAME_BITS rising edges.

Function
REQ-014 ss_n, sclk and sdi SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-015 Edge detect: a sclk rise/fall event is one clk cycle with the synchronized sclk differing from its previous-cycle copy; an event SHALL be seen 3 clk after the pin changes.
REQ-016 States: IDLE, SHIFT, DONE.
REQ-017 IDLE: on synchronized ss_n=0, latch txdata into tx_shift, clear bit counters, set busy=1, go to SHIFT.
REQ-018 SHIFT, sclk rising event: rx_shift <= {rx_shift[FRAME_BITS-2:0], sdi_sync}; rise_cnt increments.
REQ-019 SHIFT, sclk falling event with fall_cnt < FRAME_BITS-RESP_BITS: sdo <= 1; fall_cnt increments.
REQ-020 SHIFT, sclk falling event with fall_cnt >= FRAME_BITS-RESP_BITS: sdo <= tx_shift MSB; tx_shift shifts left, filling with 0; fall_cnt increments.
REQ-021 Rising event number FRAME_BITS: rxdata <= the new rx_shift value in the same cycle; rx_valid=1 for the next cycle only; go to DONE.
REQ-022 Counter widths SHALL be clog2(FRAME_BITS+1); counters SHALL saturate and never wrap.
REQ-023 DONE: ignore sclk events, sdo=1; on ss_n=1 go to IDLE and set busy=0.
REQ-024 SHIFT with ss_n=1 before rise_cnt reaches FRAME_BITS: pulse frame_err, leave rxdata unchanged, no rx_valid, sdo=1, go to IDLE.
REQ-025 If a frame's last rising event and ss_n deassertion arrive in the same cycle, the frame SHALL complete with rx_valid; frame_err SHALL NOT assert.
REQ-026 Changes to txdata after the frame start SHALL NOT affect the current frame.
REQ-027 IDLE: sdo=1; sclk events SHALL be ignored.
REQ-028 The sclk half-period SHALL be at least 8 clk; the default master (about 256 clk per half-period) meets this.

Reset
REQ-029 rst=0 SHALL asynchronously set state=IDLE, all counters and shift registers to 0, rxdata=0, sdo=1, rx_valid=0, busy=0, frame_err=0, and all synchronizer flops for ss_n and sclk to 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release no rx_valid or frame_err SHALL fire for the aborted frame.
REQ-031 After rst deasserts, the first frame SHALL be accepted only on a fresh ss_n=0 seen by the synchronizer.

Verification
REQ-032 txdata=8'hA5, master drives 16'h0B2D with sclk half-period 256 clk -> sdo=1 for bits 0-7, then sdo=1,0,1,0,0,1,0,1; rxdata=16'h0B2D; exactly one rx_valid pulse.
REQ-033 Back-to-back frames 16'hFFFF then 16'h0000, each txdata=8'h3C -> two rx_valid pulses; rxdata=16'hFFFF then 16'h0000; master receives 8'h3C both times.
REQ-034 ss_n deasserted after 9 rising edges -> one frame_err pulse; rxdata keeps its prior value; no rx_valid; busy drops within 4 clk.
REQ-035 rst=0 after 5 bits, then released, then a full frame 16'h1234 -> only that frame produces rx_valid; rxdata=16'h1234.
REQ-036 txdata changed from 8'h81 to 8'h7E mid-frame -> master receives 8'h81.
REQ-037 20 sclk cycles with ss_n held low -> rx_valid fires once after the 16th rising edge; extra edges ignored; sdo=1 in DONE.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI slave port: receives a fixed-length frame from an SPI master and
// returns a response word in the tail of the same frame. All SPI pins are
// asynchronous to clk and are resynchronised before use.
module spi_slave_port #(
    parameter int FRAME_BITS = 16,
    parameter int RESP_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  sdi,
    output logic                  sdo,
    input  logic [RESP_BITS-1:0]  txdata,
    output logic [FRAME_BITS-1:0] rxdata,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] FRAME_MAX  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] RESP_START = CW'(FRAME_BITS - RESP_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    logic ss_meta_q, ss_sync_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic sdi_meta_q, sdi_sync_q;
    logic sclk_rise, sclk_fall;

    state_t                  state_q, state_d;
    logic [RESP_BITS-1:0]    tx_shift_q, tx_shift_d;
    logic [FRAME_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [FRAME_BITS-1:0]   rx_next;
    logic [CW-1:0]           rise_cnt_q, rise_cnt_d;
    logic [CW-1:0]           fall_cnt_q, fall_cnt_d;
    logic [FRAME_BITS-1:0]   rxdata_q, rxdata_d;
    logic                    sdo_q, sdo_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_err_q, frame_err_d;

    // Two-flop synchronisers plus a delayed sclk copy for edge detection;
    // idle-high lines reset high so no spurious edge or frame start appears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            sdi_meta_q  <= 1'b0;
            sdi_sync_q  <= 1'b0;
        end else begin
            ss_meta_q   <= ss_n;
            ss_sync_q   <= ss_meta_q;
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            sdi_meta_q  <= sdi;
            sdi_sync_q  <= sdi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign rx_next   = (rx_shift_q << 1) | FRAME_BITS'(sdi_sync_q);

    // Frame state register and all datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
            rxdata_q    <= '0;
            sdo_q       <= 1'b1;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
            rxdata_q    <= rxdata_d;
            sdo_q       <= sdo_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: a completing rising edge wins over a simultaneous
    // ss_n release so that frame still counts as good.
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rise_cnt_d  = rise_cnt_q;
        fall_cnt_d  = fall_cnt_q;
        rxdata_d    = rxdata_q;
        sdo_d       = sdo_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                sdo_d = 1'b1;
                if (!ss_sync_q) begin
                    tx_shift_d = txdata;
                    rx_shift_d = '0;
                    rise_cnt_d = '0;
                    fall_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && rise_cnt_q == FRAME_LAST) begin
                    rx_shift_d = rx_next;
                    rxdata_d   = rx_next;
                    rx_valid_d = 1'b1;
                    rise_cnt_d = FRAME_MAX;
                    sdo_d      = 1'b1;
                    state_d    = DONE;
                end else if (ss_sync_q) begin
                    frame_err_d = 1'b1;
                    sdo_d       = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_next;
                    if (rise_cnt_q < FRAME_MAX) begin
                        rise_cnt_d = rise_cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (fall_cnt_q < RESP_START) begin
                        sdo_d = 1'b1;
                    end else begin
                        sdo_d      = tx_shift_q[RESP_BITS-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                    if (fall_cnt_q < FRAME_MAX) begin
                        fall_cnt_d = fall_cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                sdo_d = 1'b1;
                if (ss_sync_q) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sdo       = sdo_q;
    assign rxdata    = rxdata_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
